// File: rtl/ofm_collector.sv
// Output-feature-map collector: turns the dual-row band/tile ofm stream back into
// linear CHW addresses for two memory write ports, dropping padding pixels.
module ofm_collector #(
  parameter int DATA_W  = 25,
  parameter int TILE_W  = 16,
  parameter int TILE_H  = 5,
  parameter int TILES_X = 4,
  parameter int N_BANDS = 13,
  parameter int OFM_H   = 61,
  parameter int OFM_W   = 61,
  parameter int CH_GRP  = 8,
  parameter int CFG_W   = 2,
  parameter int ADDR_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CFG_W-1:0]  cfg_co,
  input  logic [DATA_W-1:0] ofm_port0,
  input  logic [DATA_W-1:0] ofm_port1,
  input  logic              ofm_port0_v,
  input  logic              ofm_port1_v,
  output logic              wr0_en,
  output logic [ADDR_W-1:0] wr0_addr,
  output logic [DATA_W-1:0] wr0_data,
  output logic              wr1_en,
  output logic [ADDR_W-1:0] wr1_addr,
  output logic [DATA_W-1:0] wr1_data,
  output logic              ch_done,
  output logic [7:0]        ch_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW  = (TILE_W  > 1) ? $clog2(TILE_W)  : 1;
  localparam int RW  = (TILE_H  > 1) ? $clog2(TILE_H)  : 1;
  localparam int XW  = (TILES_X > 1) ? $clog2(TILES_X) : 1;
  localparam int BW  = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
  localparam int RW1 = RW + 1;
  localparam logic [CW-1:0]  COL_MAX  = CW'(TILE_W - 1);
  localparam logic [RW-1:0]  RIB_MAX  = RW'(TILE_H - 1);
  localparam logic [RW1-1:0] RIB_LIM  = RW1'(TILE_H);
  localparam logic [XW-1:0]  TX_MAX   = XW'(TILES_X - 1);
  localparam logic [BW-1:0]  BAND_MAX = BW'(N_BANDS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  state_t state_q, state_d;
  logic [CW-1:0]  col;
  logic [RW-1:0]  rib;
  logic [XW-1:0]  tx;
  logic [BW-1:0]  band;
  logic [7:0]     ch, ch_last;
  wr_t [1:0]      wr_q, wr_d;

  logic beat, dual, drop1, adv2, arm;
  logic col_wrap, rib_wrap, tx_wrap, band_wrap, ch_wrap;
  logic [RW1-1:0] rib_sum;
  logic [ADDR_W-1:0] row_a, col_a, base;
  logic [1:0] port_v;
  logic [1:0][DATA_W-1:0] port_d;

  // A dual beat on the last band row has no partner row; only port0 is kept.
  assign arm      = start && (state_q != COLLECT);
  assign beat     = (state_q == COLLECT) && ofm_port0_v;
  assign dual     = beat && ofm_port1_v;
  assign drop1    = dual && (rib == RIB_MAX);
  assign adv2     = dual && !drop1;
  assign rib_sum  = {1'b0, rib} + (adv2 ? RW1'(2) : RW1'(1));
  assign col_wrap  = (col == COL_MAX);
  assign rib_wrap  = col_wrap && (rib_sum >= RIB_LIM);
  assign tx_wrap   = rib_wrap && (tx == TX_MAX);
  assign band_wrap = tx_wrap && (band == BAND_MAX);
  assign ch_wrap   = band_wrap && (ch == ch_last);

  assign row_a  = ADDR_W'(band) * ADDR_W'(TILE_H) + ADDR_W'(rib);
  assign col_a  = ADDR_W'(tx) * ADDR_W'(TILE_W) + ADDR_W'(col);
  assign base   = ADDR_W'(ch) * ADDR_W'(OFM_H * OFM_W) + row_a * ADDR_W'(OFM_W) + col_a;
  assign port_v = {adv2, beat};
  assign port_d = {ofm_port1, ofm_port0};

  always_comb begin
    wr_d = '0;
    for (int p = 0; p < 2; p++) begin
      wr_d[p].en   = port_v[p] && ((row_a + ADDR_W'(p)) < ADDR_W'(OFM_H)) &&
                     (col_a < ADDR_W'(OFM_W));
      wr_d[p].addr = base + ADDR_W'(p * OFM_W);
      wr_d[p].data = port_d[p];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = COLLECT;
      COLLECT:    if (beat && ch_wrap) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == COLLECT);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      ch_done <= 1'b0;
      err     <= 1'b0;
      col     <= '0;
      rib     <= '0;
      tx      <= '0;
      band    <= '0;
      ch      <= '0;
      ch_last <= '0;
    end else begin
      wr_q    <= wr_d;
      ch_done <= beat && band_wrap;
      if (arm) begin
        col     <= '0;
        rib     <= '0;
        tx      <= '0;
        band    <= '0;
        ch      <= '0;
        err     <= 1'b0;
        ch_last <= 8'((int'(cfg_co) + 1) * CH_GRP - 1);
      end else if (state_q == COLLECT) begin
        if ((ofm_port1_v && !ofm_port0_v) || drop1) err <= 1'b1;
        if (beat) begin
          col <= col_wrap ? '0 : col + 1'b1;
          if (col_wrap)  rib  <= rib_wrap ? '0 : rib_sum[RW-1:0];
          if (rib_wrap)  tx   <= tx_wrap ? '0 : tx + 1'b1;
          if (tx_wrap)   band <= band_wrap ? '0 : band + 1'b1;
          if (band_wrap) ch   <= ch_wrap ? '0 : ch + 1'b1;
        end
      end
    end
  end

  assign wr0_en   = wr_q[0].en;
  assign wr0_addr = wr_q[0].addr;
  assign wr0_data = wr_q[0].data;
  assign wr1_en   = wr_q[1].en;
  assign wr1_addr = wr_q[1].addr;
  assign wr1_data = wr_q[1].data;
  assign ch_idx   = ch;
endmodule
